// File: rtl/psum_accumulator_pkg.sv
// Shared defaults, lane/row types and FSM encoding for the partial-sum accumulator.
package psum_accumulator_pkg;

  localparam int unsigned IN_WIDTH_DEF  = 32;
  localparam int unsigned SA_LENGTH_DEF = 256;
  localparam int unsigned ROWS_DEF      = 16;

  typedef logic signed [IN_WIDTH_DEF-1:0] psum_t;
  typedef psum_t [SA_LENGTH_DEF-1:0]      psum_row_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/psum_bank.sv
// Accumulator row bank: one write port (overwrite or lane-wise add) and one async read port.
module psum_bank
  import psum_accumulator_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = IN_WIDTH_DEF,
  parameter int unsigned SA_LENGTH = SA_LENGTH_DEF,
  parameter int unsigned ROWS      = ROWS_DEF,
  parameter int unsigned ROW_W     = $clog2(ROWS)
) (
  input  logic                               clk,
  input  logic                               we,
  input  logic                               add,
  input  logic [ROW_W-1:0]                   waddr,
  input  logic [SA_LENGTH-1:0][IN_WIDTH-1:0] wdata,
  input  logic [ROW_W-1:0]                   raddr,
  output logic [SA_LENGTH-1:0][IN_WIDTH-1:0] rdata
);

  logic [SA_LENGTH-1:0][IN_WIDTH-1:0] mem [ROWS];
  logic [SA_LENGTH-1:0][IN_WIDTH-1:0] sum;

  // Two's-complement wrap is the natural behaviour of a fixed-width add.
  always_comb begin
    sum = '0;
    for (int unsigned l = 0; l < SA_LENGTH; l++) begin
      sum[l] = mem[waddr][l] + wdata[l];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= add ? sum : wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates K-tile partial-sum rows into a local bank, then drains finished rows downstream.
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = IN_WIDTH_DEF,
  parameter int unsigned SA_LENGTH = SA_LENGTH_DEF,
  parameter int unsigned ROWS      = ROWS_DEF,
  parameter int unsigned ROW_W     = $clog2(ROWS)
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic                               Start,
  input  logic [7:0]                         NumTiles,
  input  logic                               InValid,
  output logic                               InReady,
  input  logic [SA_LENGTH-1:0][IN_WIDTH-1:0] In,
  output logic                               OutValid,
  input  logic                               OutReady,
  output logic [SA_LENGTH-1:0][IN_WIDTH-1:0] Out,
  output logic [ROW_W-1:0]                   OutRow,
  output logic                               Busy,
  output logic                               Done
);

  state_t           state, state_next;
  logic [ROW_W-1:0] row;
  logic [7:0]       tile;
  logic [7:0]       tiles_total;
  logic             in_xfer, out_xfer;
  logic             row_last, tile_last;

  assign in_xfer   = InValid && InReady;
  assign out_xfer  = OutValid && OutReady;
  assign row_last  = (row == ROW_W'(ROWS - 1));
  assign tile_last = (tile == tiles_total - 8'd1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      row         <= '0;
      tile        <= '0;
      tiles_total <= 8'd1;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (Start) begin
            tiles_total <= (NumTiles == 8'd0) ? 8'd1 : NumTiles;
            row         <= '0;
            tile        <= '0;
          end
        end
        ACCUM: begin
          if (in_xfer) begin
            if (row_last) begin
              row  <= '0;
              tile <= tile + 8'd1;
            end else begin
              row <= row + ROW_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_xfer) begin
            row <= row_last ? '0 : row + ROW_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    InReady    = 1'b0;
    OutValid   = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) state_next = ACCUM;
      end
      ACCUM: begin
        InReady = 1'b1;
        Busy    = 1'b1;
        if (InValid && row_last && tile_last) state_next = DRAIN;
      end
      DRAIN: begin
        OutValid = 1'b1;
        Busy     = 1'b1;
        if (OutReady && row_last) state_next = DONE;
      end
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Row counter doubles as write address in ACCUM and read address in DRAIN.
  psum_bank #(
    .IN_WIDTH (IN_WIDTH),
    .SA_LENGTH(SA_LENGTH),
    .ROWS     (ROWS),
    .ROW_W    (ROW_W)
  ) u_bank (
    .clk  (Clk),
    .we   (in_xfer),
    .add  (tile != 8'd0),
    .waddr(row),
    .wdata(In),
    .raddr(row),
    .rdata(Out)
  );

  assign OutRow = row;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed-plus-random bench for psum_accumulator against a lane-wise summation model.
module tb_psum_accumulator;

  localparam int unsigned IW  = 32;
  localparam int unsigned SA  = 4;
  localparam int unsigned NR  = 4;
  localparam int unsigned RWW = 2;
  localparam int unsigned RB  = IW * SA;

  logic             Clk = 1'b0;
  logic             Reset, Start, InValid, OutReady;
  logic             InReady, OutValid, Busy, Done;
  logic [7:0]       NumTiles;
  logic [SA-1:0][IW-1:0] In, Out;
  logic [RWW-1:0]   OutRow;

  int checks = 0;
  int fails  = 0;

  logic [SA-1:0][IW-1:0] stim [8][NR];
  logic [SA-1:0][IW-1:0] expr [NR];
  logic [SA-1:0][IW-1:0] got  [NR];
  logic [SA-1:0][IW-1:0] gota [NR];

  always #5 Clk = ~Clk;

  psum_accumulator #(
    .IN_WIDTH (IW),
    .SA_LENGTH(SA),
    .ROWS     (NR)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .NumTiles(NumTiles),
    .InValid (InValid),
    .InReady (InReady),
    .In      (In),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .Out     (Out),
    .OutRow  (OutRow),
    .Busy    (Busy),
    .Done    (Done)
  );

  task automatic chk(input string tag, input logic [RB-1:0] obs, input logic [RB-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [RB-1:0] splat(input logic [IW-1:0] v);
    logic [RB-1:0] r;
    for (int l = 0; l < SA; l++) r[l*IW +: IW] = v;
    return r;
  endfunction

  // Reference: each output lane is the wrapped 32-bit sum of that lane over all tiles.
  task automatic compute_model(input int eff);
    for (int r = 0; r < NR; r++) begin
      for (int l = 0; l < SA; l++) begin
        logic [IW-1:0] a;
        a = '0;
        for (int t = 0; t < eff; t++) a = a + stim[t][r][l];
        expr[r][l] = a;
      end
    end
  endtask

  task automatic fill_random(input int nt);
    for (int t = 0; t < nt; t++)
      for (int r = 0; r < NR; r++)
        for (int l = 0; l < SA; l++) stim[t][r][l] = $urandom;
  endtask

  task automatic run_job(input int nt, input int gapmax);
    int eff;
    int g;
    eff = (nt == 0) ? 1 : nt;
    @(negedge Clk);
    chk("idle_inready", InReady, 0);
    chk("idle_busy", Busy, 0);
    Start    = 1'b1;
    NumTiles = nt[7:0];
    @(negedge Clk);
    Start = 1'b0;
    chk("accum_busy", Busy, 1);
    for (int t = 0; t < eff; t++) begin
      for (int r = 0; r < NR; r++) begin
        g = $urandom_range(gapmax, 0);
        repeat (g) begin
          InValid = 1'b0;
          In      = {$urandom, $urandom, $urandom, $urandom};
          chk("gap_inready", InReady, 1);
          @(negedge Clk);
        end
        InValid = 1'b1;
        In      = stim[t][r];
        chk("accum_inready", InReady, 1);
        @(negedge Clk);
      end
    end
    InValid = 1'b0;
    In      = '0;
    chk("first_outvalid", OutValid, 1);
    chk("drain_inready", InReady, 0);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready.
  task automatic drain(input int mode, input int stop_at);
    int idx;
    int cyc;
    logic rdy;
    idx = 0;
    cyc = 0;
    while (idx < NR && cyc < 200) begin
      chk("outvalid", OutValid, 1);
      chk("out_data", Out, expr[idx]);
      chk("outrow", OutRow, idx);
      got[idx] = Out;
      if (idx == stop_at) break;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(1, 0));
      OutReady = rdy;
      @(negedge Clk);
      if (rdy) idx++;
      cyc++;
    end
    if (stop_at < 0) begin
      OutReady = 1'b0;
      chk("drain_count", idx, NR);
      chk("done_pulse", Done, 1);
      chk("done_busy", Busy, 0);
      chk("done_outvalid", OutValid, 0);
      chk("done_inready", InReady, 0);
      Start    = 1'b1;
      NumTiles = 8'd1;
      @(negedge Clk);
      Start = 1'b0;
      chk("done_once", Done, 0);
      chk("start_in_done_ignored", InReady, 0);
      chk("idle_after_done", Busy, 0);
    end
  endtask

  initial begin
    Reset    = 1'b1;
    Start    = 1'b0;
    NumTiles = 8'd0;
    InValid  = 1'b0;
    OutReady = 1'b0;
    In       = '0;
    repeat (3) @(negedge Clk);
    chk("rst_inready", InReady, 0);
    chk("rst_outvalid", OutValid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_outrow", OutRow, 0);
    Reset = 1'b0;

    // Single tile, rows of constant r+1.
    for (int r = 0; r < NR; r++) stim[0][r] = splat(IW'(r + 1));
    compute_model(1);
    run_job(1, 0);
    drain(0, -1);
    for (int r = 0; r < NR; r++) chk("t1_row_value", got[r], splat(IW'(r + 1)));

    // Three tiles of 5, then one tile of 2 to prove tile 0 overwrites.
    for (int t = 0; t < 3; t++)
      for (int r = 0; r < NR; r++) stim[t][r] = splat(32'd5);
    compute_model(3);
    run_job(3, 0);
    drain(0, -1);
    for (int r = 0; r < NR; r++) chk("sum15", got[r], splat(32'd15));
    for (int r = 0; r < NR; r++) stim[0][r] = splat(32'd2);
    compute_model(1);
    run_job(1, 0);
    drain(0, -1);
    for (int r = 0; r < NR; r++) chk("overwrite2", got[r], splat(32'd2));

    // Wrap without saturation, and a signed sum.
    stim[0][0] = splat(32'h7FFF_FFFF); stim[1][0] = splat(32'd1);
    stim[0][1] = splat(32'h7FFF_FFFF); stim[1][1] = splat(32'd1);
    stim[0][2] = splat(-32'sd8);       stim[1][2] = splat(32'd3);
    stim[0][3] = splat(-32'sd8);       stim[1][3] = splat(32'd3);
    compute_model(2);
    run_job(2, 0);
    drain(1, -1);
    chk("wrap_80000000", got[0], splat(32'h8000_0000));
    chk("neg_sum_m5", got[2], splat(32'hFFFF_FFFB));

    // Random data, gap-free then with gaps: results must match each other.
    fill_random(3);
    compute_model(3);
    run_job(3, 0);
    drain(0, -1);
    for (int r = 0; r < NR; r++) gota[r] = got[r];
    run_job(3, 3);
    drain(2, -1);
    for (int r = 0; r < NR; r++) chk("gap_equiv", got[r], gota[r]);

    // Reset mid-drain at row 2, then NumTiles=0 runs as one tile.
    fill_random(2);
    compute_model(2);
    run_job(2, 2);
    drain(2, 2);
    Reset    = 1'b1;
    OutReady = 1'b0;
    @(negedge Clk);
    chk("mid_rst_outvalid", OutValid, 0);
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_done", Done, 0);
    chk("mid_rst_inready", InReady, 0);
    chk("mid_rst_outrow", OutRow, 0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("mid_rst_no_done", Done, 0);
    chk("mid_rst_idle", Busy, 0);
    fill_random(1);
    compute_model(1);
    run_job(0, 1);
    drain(2, -1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
